// File: rtl/cc_400_reader.sv
// cc_400_reader: strobes cc_400 with read_out pulses, captures the returned bytes
// and keeps count/sum/min/max statistics over N_READS reads.
module cc_400_reader #(
  parameter int N_READS   = 400,
  parameter int PULSE_LEN = 17,
  parameter int GAP_LEN   = 67,
  parameter int CNT_W     = 9,
  parameter int SUM_W     = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             up_state,
  input  logic [7:0]       num,
  output logic             read_out,
  output logic [7:0]       sample,
  output logic             sample_vld,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [SUM_W-1:0] sum,
  output logic [7:0]       min_val,
  output logic [7:0]       max_val,
  output logic             busy,
  output logic             done
);
  localparam int TMR_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, PULSE, CAPTURE, GAP, DONE} state_t;

  state_t           r_state, w_next;
  logic [TMR_W-1:0] r_tmr;
  logic             r_start_q, r_armed;
  logic             w_rise, w_busy_st, w_pulse_end, w_gap_end;
  logic [CNT_W-1:0] w_cnt_nxt;

  // r_armed blocks a start that is already high when reset releases
  assign w_rise      = start & ~r_start_q & r_armed;
  assign w_busy_st   = r_state inside {WAIT_RDY, PULSE, CAPTURE, GAP};
  assign w_pulse_end = r_tmr == TMR_W'(PULSE_LEN - 1);
  assign w_gap_end   = r_tmr == TMR_W'(GAP_LEN - 1);
  assign w_cnt_nxt   = rd_cnt + 1'b1;

  // The last GAP cycle jumps straight to PULSE when ready, keeping the period at PULSE_LEN+1+GAP_LEN
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = w_rise ? WAIT_RDY : IDLE;
      WAIT_RDY: w_next = up_state ? PULSE : WAIT_RDY;
      PULSE:    w_next = w_pulse_end ? CAPTURE : PULSE;
      CAPTURE:  w_next = (w_cnt_nxt == CNT_W'(N_READS)) ? DONE : GAP;
      GAP:      w_next = !w_gap_end ? GAP : (up_state ? PULSE : WAIT_RDY);
      DONE:     w_next = start ? DONE : IDLE;
      default:  w_next = IDLE;
    endcase
    if (w_busy_st && !start) w_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tmr      <= '0;
      r_start_q  <= 1'b0;
      r_armed    <= 1'b0;
      read_out   <= 1'b0;
      sample     <= '0;
      sample_vld <= 1'b0;
      rd_cnt     <= '0;
      sum        <= '0;
      min_val    <= 8'hFF;
      max_val    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tmr      <= (w_next == r_state) ? r_tmr + 1'b1 : '0;
      r_start_q  <= start;
      r_armed    <= r_armed | ~start;
      read_out   <= w_next == PULSE;
      busy       <= w_next inside {WAIT_RDY, PULSE, CAPTURE, GAP};
      done       <= w_next == DONE;
      sample_vld <= 1'b0;
      if (r_state == IDLE && w_rise) begin
        rd_cnt  <= '0;
        sum     <= '0;
        sample  <= '0;
        min_val <= 8'hFF;
        max_val <= '0;
      end
      if (r_state == CAPTURE && w_next != IDLE) begin
        sample     <= num;
        sample_vld <= 1'b1;
        sum        <= sum + SUM_W'(num);
        rd_cnt     <= w_cnt_nxt;
        min_val    <= (num < min_val) ? num : min_val;
        max_val    <= (num > max_val) ? num : max_val;
      end
    end
  end
endmodule

// File: tb/tb_cc_400_reader.sv
// tb_cc_400_reader: directed bench for cc_400_reader; a default-parameter instance plus
// a 4-read instance for the constant-data run.
`timescale 1ns/1ps
module tb_cc_400_reader;
  logic        clk = 1'b0;
  logic        rst, start, up_state;
  logic [7:0]  num;
  logic        read_out, sample_vld, busy, done;
  logic [7:0]  sample, min_val, max_val;
  logic [8:0]  rd_cnt;
  logic [16:0] sum;

  logic        start_s, up_s;
  logic [7:0]  num_s;
  logic        read_out_s, sample_vld_s, busy_s, done_s;
  logic [7:0]  sample_s, min_s, max_s;
  logic [2:0]  rd_cnt_s;
  logic [10:0] sum_s;

  int tests = 0, fails = 0;
  int cyc = 0, run = 0, last_lo = 0, last_hi = 0, npulse = 0, nvld = 0;
  logic prev_ro = 1'b0, rose, fell;

  always #5 clk = ~clk;

  cc_400_reader u_dut (
    .clk(clk), .rst(rst), .start(start), .up_state(up_state), .num(num),
    .read_out(read_out), .sample(sample), .sample_vld(sample_vld), .rd_cnt(rd_cnt),
    .sum(sum), .min_val(min_val), .max_val(max_val), .busy(busy), .done(done)
  );

  cc_400_reader #(.N_READS(4), .PULSE_LEN(2), .GAP_LEN(3), .CNT_W(3), .SUM_W(11)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .up_state(up_s), .num(num_s),
    .read_out(read_out_s), .sample(sample_s), .sample_vld(sample_vld_s), .rd_cnt(rd_cnt_s),
    .sum(sum_s), .min_val(min_s), .max_val(max_s), .busy(busy_s), .done(done_s)
  );

  // cc_400 model: each new strobe presents byte (pulse index mod 256)
  task automatic tick();
    @(negedge clk);
    cyc++;
    rose = 1'b0;
    fell = 1'b0;
    if (read_out !== prev_ro) begin
      if (read_out) begin
        last_lo = run;
        rose = 1'b1;
        num = 8'(npulse);
        npulse++;
      end else begin
        last_hi = run;
        fell = 1'b1;
      end
      run = 1;
    end else run++;
    prev_ro = read_out;
    if (sample_vld) nvld++;
  endtask

  task automatic new_run();
    start = 1'b0;
    repeat (2) tick();
    npulse = 0;
    nvld = 0;
    start = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; up_state = 1'b1; num = 8'h00;
    start_s = 1'b0; up_s = 1'b1; num_s = 8'h80;
    repeat (3) tick();
    tests++;
    if ({read_out, sample, sample_vld, rd_cnt, sum, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_zero: ro=%b smp=%h vld=%b cnt=%0d sum=%0d busy=%b done=%b, expected all 0",
               read_out, sample, sample_vld, rd_cnt, sum, busy, done);
    end
    tests++;
    if (min_val !== 8'hFF || max_val !== 8'h00) begin
      fails++;
      $display("FAIL reset_minmax: min=%h max=%h, expected FF/00", min_val, max_val);
    end
    rst = 1'b0;
  endtask

  task automatic test_start_held();
    rst = 1'b1; start = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    tests++;
    if (busy !== 1'b0 || read_out !== 1'b0) begin
      fails++;
      $display("FAIL start_held_norun: busy=%b ro=%b, expected 0/0", busy, read_out);
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    repeat (2) tick();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL start_toggle_runs: busy=%b, expected 1", busy);
    end
    start = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_nominal();
    int t0 = -1, td = -1, bad_hi = 0, bad_lo = 0, exp_sum = 0;
    for (int k = 0; k < 400; k++) exp_sum += k % 256;
    up_state = 1'b1;
    new_run();
    for (int i = 0; i < 40000; i++) begin
      tick();
      if (rose && t0 < 0) t0 = cyc;
      if (rose && npulse > 1 && last_lo != 68) bad_lo++;
      if (fell && last_hi != 17) bad_hi++;
      if (done) begin td = cyc; break; end
    end
    tests++;
    if (td < 0 || td - t0 != 33933) begin
      fails++;
      $display("FAIL nom_done_time: %0d cycles from first strobe, expected 33933", td - t0);
    end
    tests++;
    if (bad_hi != 0 || bad_lo != 0) begin
      fails++;
      $display("FAIL nom_strobe_shape: %0d bad highs, %0d bad lows (last hi=%0d lo=%0d), expected 0/0",
               bad_hi, bad_lo, last_hi, last_lo);
    end
    tests++;
    if (rd_cnt !== 9'd400 || nvld != 400) begin
      fails++;
      $display("FAIL nom_count: rd_cnt=%0d vld=%0d, expected 400/400", rd_cnt, nvld);
    end
    tests++;
    if (sum !== 17'(exp_sum)) begin
      fails++;
      $display("FAIL nom_sum: sum=%0d, expected %0d", sum, exp_sum);
    end
    tests++;
    if (min_val !== 8'h00 || max_val !== 8'hFF || sample !== 8'd143) begin
      fails++;
      $display("FAIL nom_minmax: min=%h max=%h last=%0d, expected 00/FF/143", min_val, max_val, sample);
    end
    repeat (20) tick();
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || read_out !== 1'b0 || rd_cnt !== 9'd400) begin
      fails++;
      $display("FAIL nom_frozen: done=%b busy=%b ro=%b cnt=%0d, expected 1/0/0/400", done, busy, read_out, rd_cnt);
    end
    start = 1'b0;
    repeat (2) tick();
    tests++;
    if (done !== 1'b0 || sum !== 17'(exp_sum) || rd_cnt !== 9'd400) begin
      fails++;
      $display("FAIL nom_idle_hold: done=%b sum=%0d cnt=%0d, expected 0/%0d/400", done, sum, rd_cnt, exp_sum);
    end
  endtask

  task automatic test_flow();
    int bad = 0;
    bit seen = 0;
    up_state = 1'b1;
    new_run();
    for (int i = 0; i < 2000 && nvld < 11; i++) tick();
    repeat (66) tick();
    up_state = 1'b0;
    repeat (50) begin
      tick();
      if (read_out !== 1'b0 || nvld != 11) bad++;
    end
    up_state = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rose) begin seen = 1; break; end
    end
    tests++;
    if (!seen || last_lo != 118) begin
      fails++;
      $display("FAIL flow_stall: low run=%0d (seen=%0d), expected 118", last_lo, seen);
    end
    tests++;
    if (bad != 0 || nvld != 11) begin
      fails++;
      $display("FAIL flow_no_extra: %0d bad stall cycles, vld=%0d, expected 0/11", bad, nvld);
    end
    start = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_abort();
    up_state = 1'b1;
    new_run();
    for (int i = 0; i < 2000 && !(nvld == 5 && read_out); i++) tick();
    repeat (3) tick();
    tests++;
    if (read_out !== 1'b1) begin
      fails++;
      $display("FAIL abort_in_pulse: ro=%b, expected 1", read_out);
    end
    start = 1'b0;
    tick();
    tests++;
    if (read_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_cnt !== 9'd5) begin
      fails++;
      $display("FAIL abort_stop: ro=%b busy=%b done=%b cnt=%0d, expected 0/0/0/5", read_out, busy, done, rd_cnt);
    end
    tests++;
    if (sum !== 17'd10 || min_val !== 8'd0 || max_val !== 8'd4) begin
      fails++;
      $display("FAIL abort_partial: sum=%0d min=%0d max=%0d, expected 10/0/4", sum, min_val, max_val);
    end
    start = 1'b1;
    tick();
    tests++;
    if (rd_cnt !== 9'd0 || sum !== 17'd0 || min_val !== 8'hFF || max_val !== 8'h00 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_restart: cnt=%0d sum=%0d min=%h max=%h busy=%b, expected 0/0/FF/00/1",
               rd_cnt, sum, min_val, max_val, busy);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2000 && !(nvld >= 2 && read_out); i++) tick();
    rst = 1'b1;
    #1;
    tests++;
    if (read_out !== 1'b0 || min_val !== 8'hFF || max_val !== 8'h00 || rd_cnt !== 9'd0 || sum !== 17'd0) begin
      fails++;
      $display("FAIL reset_async: ro=%b min=%h max=%h cnt=%0d sum=%0d, expected 0/FF/00/0/0",
               read_out, min_val, max_val, rd_cnt, sum);
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    tests++;
    if (busy !== 1'b0 || read_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b ro=%b, expected 0/0 with start held", busy, read_out);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_const();
    int nv = 0;
    start_s = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (sample_vld_s) nv++;
      if (done_s) break;
    end
    tests++;
    if (done_s !== 1'b1 || rd_cnt_s !== 3'd4 || nv != 4) begin
      fails++;
      $display("FAIL const_count: done=%b cnt=%0d vld=%0d, expected 1/4/4", done_s, rd_cnt_s, nv);
    end
    tests++;
    if (sum_s !== 11'd512 || min_s !== 8'h80 || max_s !== 8'h80) begin
      fails++;
      $display("FAIL const_stats: sum=%0d min=%h max=%h, expected 512/80/80", sum_s, min_s, max_s);
    end
    start_s = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_start_held();
    test_nominal();
    test_flow();
    test_abort();
    test_reset_mid();
    test_const();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
